// File: rtl/pipe_delay_pkg.sv
// pipe_delay_pkg: shared helpers for the core's delay-line blocks.
// Tap-width sizing and depth sanity check.
package pipe_delay_pkg;

  localparam int PD_DEPTH_DEF = 3;
  localparam int PD_WIDTH_DEF = 32;

  // Width needed to encode a tap select of 0..depth.
  function automatic int sel_w(input int depth);
    int w;
    w = $clog2(depth + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

  // A delay line needs at least one register stage.
  function automatic bit depth_ok(input int depth);
    return depth >= 1;
  endfunction

endpackage

// File: rtl/pipe_delay_stage.sv
// pipe_delay_stage: one {valid, data} register of the delay line.
// Payload is forced to zero whenever the captured valid is low.
module pipe_delay_stage
  import pipe_delay_pkg::*;
#(
  parameter int WIDTH = PD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  // Reset beats flush beats advance; stall holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= in_valid ? in_data : '0;
    end
  end

endmodule

// File: rtl/pipe_delay.sv
// pipe_delay: stallable, flushable delay line with run-time tap select.
// Optional occupancy counter enabled by PIPE_DELAY_OCC_EN.
module pipe_delay
  import pipe_delay_pkg::*;
#(
  parameter int DEPTH = PD_DEPTH_DEF,
  parameter int WIDTH = PD_WIDTH_DEF,
  parameter int SELW  = sel_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SELW-1:0]  dly_sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_DELAY_OCC_EN
  ,
  output logic [SELW-1:0]  occ
`endif
);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("pipe_delay: DEPTH must be >= 1");
  end

  logic             sv [1:DEPTH];
  logic [WIDTH-1:0] sd [1:DEPTH];
  logic [SELW-1:0]  eff_sel;

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    logic             iv;
    logic [WIDTH-1:0] id;
    if (k == 1) begin : g_head
      assign iv = in_valid;
      assign id = in_data;
    end else begin : g_link
      assign iv = sv[k-1];
      assign id = sd[k-1];
    end
    pipe_delay_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .flush    (flush),
      .in_valid (iv),
      .in_data  (id),
      .out_valid(sv[k]),
      .out_data (sd[k])
    );
  end

  // Out-of-range selects (0 or above DEPTH) fall back to the deepest tap.
  always_comb begin
    eff_sel = dly_sel;
    if (dly_sel == '0 || 32'(dly_sel) > 32'(DEPTH))
      eff_sel = SELW'(DEPTH);
  end

  // Tap mux straight off the stage registers.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (32'(eff_sel) == 32'(k)) begin
        out_valid = sv[k];
        out_data  = sd[k];
      end
    end
  end

`ifdef PIPE_DELAY_OCC_EN
  // Occupancy tracks entries in minus the entry falling off the end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ <= '0;
    end else if (flush) begin
      occ <= '0;
    end else if (en) begin
      occ <= occ + SELW'(in_valid) - SELW'(sv[DEPTH]);
    end
  end
`endif

endmodule
